// File: rtl/stfq_rank_computer.sv
// stfq_rank_computer
// Start-Time Fair Queueing rank computation placed directly in front of the
// flow PIFO. Each accepted packet gets rank = max(virtual_time, last_finish[f]).
// The flow's finish tag then advances by length >> shift[f] and saturates
// instead of wrapping. Virtual time follows the PIFO's dequeue priority and
// never moves backwards. The result is presented through a single registered
// valid/ready stage.
module stfq_rank_computer #(
  parameter int NUM_FLOWS      = 16,
  parameter int PRIORITY_WIDTH = 16,
  parameter int LENGTH_WIDTH   = 11,
  parameter int POINTER_WIDTH  = 10,
  parameter int SHIFT_WIDTH    = 4,
  localparam int FLOW_W        = (NUM_FLOWS > 1) ? $clog2(NUM_FLOWS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  // arriving packet
  input  logic                      i__pkt_valid,
  input  logic [FLOW_W-1:0]         i__pkt_flow_id,
  input  logic [LENGTH_WIDTH-1:0]   i__pkt_length,
  input  logic [POINTER_WIDTH-1:0]  i__pkt_pointer,
  output logic                      o__pkt_ready,
  // PIFO enqueue interface
  output logic                      o__enq_valid,
  output logic [FLOW_W-1:0]         o__enq_flow_id,
  output logic [PRIORITY_WIDTH-1:0] o__enq_priority,
  output logic [POINTER_WIDTH-1:0]  o__enq_pointer,
  input  logic                      i__enq_ready,
  // PIFO dequeue feedback
  input  logic                      i__deq_valid,
  input  logic [PRIORITY_WIDTH-1:0] i__deq_priority,
  // weight configuration
  input  logic                      i__cfg_valid,
  input  logic [FLOW_W-1:0]         i__cfg_flow_id,
  input  logic [SHIFT_WIDTH-1:0]    i__cfg_shift,
  output logic                      o__saturated
);

  // Per-flow state. Both arrays are flops, so they can be read
  // combinationally in the same cycle the packet arrives.
  logic [PRIORITY_WIDTH-1:0] last_finish [NUM_FLOWS];
  logic [SHIFT_WIDTH-1:0]    shift       [NUM_FLOWS];
  logic [PRIORITY_WIDTH-1:0] virtual_time;

  logic                      accept;
  logic                      pkt_in_range;
  logic                      cfg_in_range;
  logic [PRIORITY_WIDTH-1:0] cur_tag;
  logic [SHIFT_WIDTH-1:0]    cur_shift;
  logic [PRIORITY_WIDTH-1:0] start_tag;
  logic [PRIORITY_WIDTH-1:0] cost;
  logic [PRIORITY_WIDTH:0]   finish_wide;
  logic                      tag_overflow;
  logic [PRIORITY_WIDTH-1:0] finish_tag;

  // Flow ids can exceed NUM_FLOWS only when NUM_FLOWS is not a power of two.
  // Such packets bypass the tag array, and config writes to them are dropped.
  assign pkt_in_range = ({{(32-FLOW_W){1'b0}}, i__pkt_flow_id} < 32'(NUM_FLOWS));
  assign cfg_in_range = ({{(32-FLOW_W){1'b0}}, i__cfg_flow_id} < 32'(NUM_FLOWS));

  // The input is free when the output slot is empty or is draining this cycle.
  assign o__pkt_ready = ~o__enq_valid | i__enq_ready;
  assign accept       = i__pkt_valid & o__pkt_ready;

  // Compute the start tag, cost and saturating finish tag from current register values.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cur_tag   = '0;
    cur_shift = '0;
    if (pkt_in_range) begin
      cur_tag   = last_finish[i__pkt_flow_id];
      cur_shift = shift[i__pkt_flow_id];
    end
    start_tag    = (pkt_in_range && (cur_tag > virtual_time)) ? cur_tag : virtual_time;
    cost         = PRIORITY_WIDTH'(i__pkt_length >> cur_shift);
    finish_wide  = {1'b0, start_tag} + {1'b0, cost};
    tag_overflow = finish_wide[PRIORITY_WIDTH];
    finish_tag   = tag_overflow ? '1 : finish_wide[PRIORITY_WIDTH-1:0];
  end

  // Output stage: load on accept, drop when drained, hold while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o__enq_valid    <= 1'b0;
      o__enq_flow_id  <= '0;
      o__enq_priority <= '0;
      o__enq_pointer  <= '0;
    end else if (accept) begin
      // NOTE: registered state uses non-blocking assignments, so every block reads pre-edge values.
      o__enq_valid    <= 1'b1;
      o__enq_flow_id  <= i__pkt_flow_id;
      o__enq_priority <= start_tag;
      o__enq_pointer  <= i__pkt_pointer;
    end else if (i__enq_ready) begin
      o__enq_valid    <= 1'b0;
    end
  end

  // Update the accepted flow's finish tag at the same edge its rank is registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the tag array is reset explicitly because STFQ fairness relies on all flows starting at 0.
      for (int f = 0; f < NUM_FLOWS; f++) begin
        last_finish[f] <= '0;
      end
    end else if (accept && pkt_in_range) begin
      last_finish[i__pkt_flow_id] <= finish_tag;
    end
  end

  // Weight shift table. A write becomes visible starting in the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int f = 0; f < NUM_FLOWS; f++) begin
        shift[f] <= '0;
      end
    end else if (i__cfg_valid && cfg_in_range) begin
      shift[i__cfg_flow_id] <= i__cfg_shift;
    end
  end

  // Virtual time follows the largest dequeued priority seen so far.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      virtual_time <= '0;
    end else if (i__deq_valid && (i__deq_priority > virtual_time)) begin
      virtual_time <= i__deq_priority;
    end
  end

  // Sticky flag that records any finish tag that clipped at the maximum value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o__saturated <= 1'b0;
    end else if (accept && pkt_in_range && tag_overflow) begin
      o__saturated <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stfq_rank_computer.sv
// tb_stfq_rank_computer
// Self-checking bench: directed scenarios followed by randomized traffic.
// A behavioural STFQ model predicts every output after each clock edge.
module tb_stfq_rank_computer;

  localparam int NF = 16;
  localparam int PMAX = 65535;

  logic        clk;
  logic        reset;
  logic        pkt_valid;
  logic [3:0]  pkt_flow_id;
  logic [10:0] pkt_length;
  logic [9:0]  pkt_pointer;
  logic        pkt_ready;
  logic        enq_valid;
  logic [3:0]  enq_flow_id;
  logic [15:0] enq_priority;
  logic [9:0]  enq_pointer;
  logic        enq_ready;
  logic        deq_valid;
  logic [15:0] deq_priority;
  logic        cfg_valid;
  logic [3:0]  cfg_flow_id;
  logic [3:0]  cfg_shift;
  logic        saturated;

  stfq_rank_computer dut (
    .clk             (clk),
    .reset           (reset),
    .i__pkt_valid    (pkt_valid),
    .i__pkt_flow_id  (pkt_flow_id),
    .i__pkt_length   (pkt_length),
    .i__pkt_pointer  (pkt_pointer),
    .o__pkt_ready    (pkt_ready),
    .o__enq_valid    (enq_valid),
    .o__enq_flow_id  (enq_flow_id),
    .o__enq_priority (enq_priority),
    .o__enq_pointer  (enq_pointer),
    .i__enq_ready    (enq_ready),
    .i__deq_valid    (deq_valid),
    .i__deq_priority (deq_priority),
    .i__cfg_valid    (cfg_valid),
    .i__cfg_flow_id  (cfg_flow_id),
    .i__cfg_shift    (cfg_shift),
    .o__saturated    (saturated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state, kept as plain integers.
  int m_lf [NF];
  int m_sh [NF];
  int m_vt;
  int m_sat;
  int m_valid;
  int m_prio;
  int m_flow;
  int m_ptr;

  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int f = 0; f < NF; f++) begin
      m_lf[f] = 0;
      m_sh[f] = 0;
    end
    m_vt = 0; m_sat = 0; m_valid = 0; m_prio = 0; m_flow = 0; m_ptr = 0;
  endtask

  task automatic idle_inputs();
    pkt_valid = 1'b0; pkt_flow_id = '0; pkt_length = '0; pkt_pointer = '0;
    deq_valid = 1'b0; deq_priority = '0;
    cfg_valid = 1'b0; cfg_flow_id = '0; cfg_shift = '0;
  endtask

  // Advance the model by one clock using the inputs in place, then compare the DUT after the edge.
  task automatic tick();
    int f, st, fin;
    bit acc;
    acc = pkt_valid && (m_valid == 0 || enq_ready);
    if (acc) begin
      f   = int'(pkt_flow_id);
      st  = (m_lf[f] > m_vt) ? m_lf[f] : m_vt;
      fin = st + (int'(pkt_length) >> m_sh[f]);
      if (fin > PMAX) begin
        fin   = PMAX;
        m_sat = 1;
      end
      m_lf[f] = fin;
      m_valid = 1; m_prio = st; m_flow = f; m_ptr = int'(pkt_pointer);
    end else if (enq_ready) begin
      m_valid = 0;
    end
    if (deq_valid && int'(deq_priority) > m_vt) m_vt = int'(deq_priority);
    if (cfg_valid) m_sh[cfg_flow_id] = int'(cfg_shift);
    @(posedge clk);
    #1;
    check("enq_valid", 32'(enq_valid), 32'(m_valid));
    if (m_valid != 0) begin
      check("enq_priority", 32'(enq_priority), 32'(m_prio));
      check("enq_flow_id", 32'(enq_flow_id), 32'(m_flow));
      check("enq_pointer", 32'(enq_pointer), 32'(m_ptr));
    end
    check("saturated", 32'(saturated), 32'(m_sat));
    check("pkt_ready", 32'(pkt_ready), 32'((m_valid == 0) || enq_ready));
  endtask

  task automatic send(input int f, input int len, input int ptr);
    pkt_valid = 1'b1; pkt_flow_id = 4'(f); pkt_length = 11'(len); pkt_pointer = 10'(ptr);
    tick();
    pkt_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    check("rst_enq_valid", 32'(enq_valid), 32'd0);
    check("rst_enq_priority", 32'(enq_priority), 32'd0);
    check("rst_saturated", 32'(saturated), 32'd0);
    check("rst_pkt_ready", 32'(pkt_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic random_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      pkt_valid    = ($urandom % 4) != 0;
      pkt_flow_id  = 4'($urandom % NF);
      pkt_length   = 11'($urandom % 2048);
      pkt_pointer  = 10'($urandom % 1024);
      enq_ready    = ($urandom % 4) != 0;
      deq_valid    = ($urandom % 4) == 0;
      if ($urandom % 3 == 0)
        deq_priority = 16'($urandom_range(0, m_vt));
      else
        deq_priority = 16'((m_vt + int'($urandom_range(0, 400)) > PMAX) ? PMAX
                                                                        : m_vt + int'($urandom_range(0, 400)));
      cfg_valid    = ($urandom % 8) == 0;
      cfg_flow_id  = 4'($urandom % NF);
      cfg_shift    = 4'($urandom % 6);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    enq_ready = 1'b1;
    do_reset();

    // Back-to-back packets on flow 0 with shift 0.
    cfg_valid = 1'b1; cfg_flow_id = 4'd0; cfg_shift = 4'd0;
    tick();
    cfg_valid = 1'b0;
    send(0, 100, 1);
    check("f0_rank_a", 32'(enq_priority), 32'd0);
    send(0, 50, 2);
    check("f0_rank_b", 32'(enq_priority), 32'd100);
    send(0, 0, 3);
    check("f0_tag", 32'(enq_priority), 32'd150);

    // Weighted flow 1, shift 2.
    cfg_valid = 1'b1; cfg_flow_id = 4'd1; cfg_shift = 4'd2;
    tick();
    cfg_valid = 1'b0;
    send(1, 100, 4);
    check("f1_rank_a", 32'(enq_priority), 32'd0);
    send(1, 8, 5);
    check("f1_rank_b", 32'(enq_priority), 32'd25);
    send(1, 0, 6);
    check("f1_tag", 32'(enq_priority), 32'd27);

    // Stall: one result is pending while flow 3 waits five cycles.
    tick();
    enq_ready = 1'b0;
    send(7, 5, 7);
    pkt_valid = 1'b1; pkt_flow_id = 4'd3; pkt_length = 11'd40; pkt_pointer = 10'd8;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_ready", 32'(pkt_ready), 32'd0);
      check("stall_hold", 32'(enq_pointer), 32'd7);
    end
    enq_ready = 1'b1;
    #1;
    check("stall_release_ready", 32'(pkt_ready), 32'd1);
    tick();
    pkt_valid = 1'b0;
    check("f3_rank", 32'(enq_priority), 32'd0);
    check("f3_ptr", 32'(enq_pointer), 32'd8);

    // Same cycle: config, dequeue and accept for flow 5.
    cfg_valid = 1'b1; cfg_flow_id = 4'd5; cfg_shift = 4'd3;
    deq_valid = 1'b1; deq_priority = 16'd200;
    send(5, 64, 9);
    idle_inputs();
    check("f5_rank_a", 32'(enq_priority), 32'd0);
    send(5, 64, 10);
    check("f5_rank_b", 32'(enq_priority), 32'd200);
    send(5, 0, 11);
    check("f5_tag", 32'(enq_priority), 32'd208);

    // Virtual time advances from dequeue feedback and never decreases.
    deq_valid = 1'b1; deq_priority = 16'd500;
    tick();
    deq_valid = 1'b0;
    send(2, 10, 12);
    check("vt_rank", 32'(enq_priority), 32'd500);
    deq_valid = 1'b1; deq_priority = 16'd300;
    tick();
    deq_valid = 1'b0;
    send(6, 0, 13);
    check("vt_monotonic", 32'(enq_priority), 32'd500);

    // Saturation of a finish tag.
    deq_valid = 1'b1; deq_priority = 16'd65500;
    tick();
    deq_valid = 1'b0;
    send(4, 100, 14);
    check("sat_rank", 32'(enq_priority), 32'd65500);
    check("sat_flag", 32'(saturated), 32'd1);
    send(4, 0, 15);
    check("sat_tag", 32'(enq_priority), 32'd65535);
    tick();
    check("sat_sticky", 32'(saturated), 32'd1);

    // Random traffic, a reset during operation, then more random traffic.
    random_cycles(400);
    #1;
    do_reset();
    random_cycles(600);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stfq_rank_computer.md
Name: stfq_rank_computer

Overview:
- Sits directly upstream of the flow PIFO and computes each arriving packet's enqueue priority (rank) using Start-Time Fair Queueing.
- Keeps per-flow last-finish tags and a global virtual time. Virtual time advances from the PIFO's dequeue-priority feedback.
- Emits flow id, rank and packet pointer to the PIFO enqueue interface through a registered valid/ready stage.

Parameters:
- NUM_FLOWS, 16, number of flows; flow id width FLOW_W = $clog2(NUM_FLOWS).
- PRIORITY_WIDTH, 16, rank / virtual-time / finish-tag width.
- LENGTH_WIDTH, 11, packet length width in bytes.
- POINTER_WIDTH, 10, packet pointer width.
- SHIFT_WIDTH, 4, per-flow weight shift width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- i__pkt_valid  input  1  arriving packet valid
- i__pkt_flow_id  input  FLOW_W  arriving packet flow
- i__pkt_length  input  LENGTH_WIDTH  packet length
- i__pkt_pointer  input  POINTER_WIDTH  packet pointer
- o__pkt_ready  output  1  block can accept a packet this cycle
- o__enq_valid  output  1  rank result valid toward the PIFO
- o__enq_flow_id  output  FLOW_W  flow id toward the PIFO
- o__enq_priority  output  PRIORITY_WIDTH  computed rank (start tag)
- o__enq_pointer  output  POINTER_WIDTH  packet pointer toward the PIFO
- i__enq_ready  input  1  PIFO accepts the result (equals ~pifo_full)
- i__deq_valid  input  1  PIFO dequeued an element this cycle
- i__deq_priority  input  PRIORITY_WIDTH  priority of the dequeued element
- i__cfg_valid  input  1  weight-shift write strobe
- i__cfg_flow_id  input  FLOW_W  flow whose shift is written
- i__cfg_shift  input  SHIFT_WIDTH  new shift (cost = length >> shift)
- o__saturated  output  1  sticky flag: some finish tag saturated

Behaviour:
- Reset (asynchronous, active-high):
  - all last_finish[f] = 0, shift[f] = 0, virtual_time = 0;
  - o__enq_valid = 0, o__enq_flow_id = 0, o__enq_priority = 0, o__enq_pointer = 0, o__saturated = 0;
  - o__pkt_ready = 1 after reset.
- Handshake:
  - o__pkt_ready = ~o__enq_valid | i__enq_ready (combinational).
  - An input is accepted when i__pkt_valid & o__pkt_ready.
  - The output register loads on accept. It clears valid when i__enq_ready is high and no accept occurs. It holds all output fields stable while o__enq_valid & ~i__enq_ready.
  - Latency: exactly 1 cycle from accept to o__enq_valid.
  - Sustained throughput: 1 packet per cycle while i__enq_ready = 1.
- Rank arithmetic, on accept of flow f with length L:
  - start = max(virtual_time, last_finish[f]), using current register values.
  - cost = L >> shift[f], zero-extended to PRIORITY_WIDTH.
  - finish = start + cost, computed at PRIORITY_WIDTH+1 bits.
    - If bit PRIORITY_WIDTH is set, finish = all-ones and o__saturated is set (sticky until reset).
    - There is no wrap-around.
  - o__enq_priority <= start. last_finish[f] <= finish at the same edge.
  - The per-flow tag array is a flop array read combinationally. Back-to-back packets of the same flow therefore see the updated tag with no hazard.
- Virtual time:
  - On i__deq_valid: virtual_time <= max(virtual_time, i__deq_priority). It is monotonic and never decreases.
  - A dequeue update and an accept in the same cycle: the packet uses the pre-update virtual_time.
- Config:
  - On i__cfg_valid: shift[i__cfg_flow_id] <= i__cfg_shift.
  - A config write and an accept for the same flow in the same cycle: the packet uses the old shift. The new shift applies from the next cycle.
- Stall:
  - While o__enq_valid & ~i__enq_ready, no accept occurs and no last_finish update occurs.
  - virtual_time and config updates still occur during a stall.
- Out-of-range flow ids (≥ NUM_FLOWS when not a power of 2): the packet passes through with rank = virtual_time and no tag update. Config writes to such ids are ignored.
- Reset mid-operation: any held output is dropped and all tags are cleared. No partial update survives.

Test Plan:
- Reset, cfg shift[0]=0, send flow 0 L=100, then flow 0 L=50 back to back, i__enq_ready=1 -> ranks 0 then 100, one cycle after each accept; last_finish[0]=150.
- Set shift[1]=2, vt=0, send flow 1 L=100 then L=8 -> ranks 0, 25; last_finish[1]=27.
- Drive i__deq_valid with priority 500, then send flow 2 L=10 (tag 0) -> rank 500; a later dequeue with priority 300 leaves vt=500.
- Hold i__enq_ready=0 with one result pending, present flow 3 L=40 -> o__pkt_ready=0, output fields unchanged for 5 cycles; raise ready -> packet accepted same cycle, rank 0 appears next cycle.
- PRIORITY_WIDTH=16, drive deq priority 65500, send flow 4 L=100 -> rank 65500, last_finish[4]=65535, o__saturated=1 and stays high.
- Same cycle: cfg shift[5]=3, deq priority 200, accept flow 5 L=64 (vt=0) -> rank 0, last_finish[5]=64; next packet flow 5 L=64 -> rank 200, last_finish[5]=208.
